noc_switch_allocator: RTL

- Sequential switch allocator for one VC of a NoC router.
- Arbitrates routed head/body/tail requests from all input ports onto output ports, using round-robin priority.
- Holds per-output wormhole locks (occupied = full bit + owner port) across cycles.
- Tracks per-output downstream credits, returns same-cycle accept to inputs, and drives registered crossbar selects.

---
 rtl/noc_switch_allocator_pkg.sv | 33 +++
 rtl/noc_switch_allocator_credit.sv | 40 ++++
 rtl/noc_switch_allocator.sv | 124 ++++++++++++
 3 files changed

// File: rtl/noc_switch_allocator_pkg.sv
// Shared constants and helpers for the NoC switch allocator and its credit counters.
package noc_switch_allocator_pkg;

  localparam int PORTS_DEF      = 5;
  localparam int LOG_PORTS_DEF  = 3;
  localparam int CREDIT_MAX_DEF = 4;
  localparam int CREDIT_W_DEF   = 3;

  // Occupied record: full bit at the MSB, owner port number below it.
  localparam int OCCUPIEDS_SIZE   = 1 + LOG_PORTS_DEF;
  localparam int OCCUPIED_IS_FULL = OCCUPIEDS_SIZE - 1;

  typedef enum logic [1:0] {
    CR_HOLD,
    CR_DEC,
    CR_INC,
    CR_BOTH
  } credit_op_e;

  function automatic credit_op_e credit_op(input logic dec, input logic inc);
    case ({dec, inc})
      2'b10:   return CR_DEC;
      2'b01:   return CR_INC;
      2'b11:   return CR_BOTH;
      default: return CR_HOLD;
    endcase
  endfunction

  function automatic int next_port(input int p, input int ports);
    return (p + 1 == ports) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/noc_switch_allocator_credit.sv
// Per-output downstream credit counter; resets full and saturates at CREDIT_MAX.
module noc_credit_counter
  import noc_switch_allocator_pkg::*;
#(
  parameter int CREDIT_MAX = CREDIT_MAX_DEF,
  parameter int CREDIT_W   = CREDIT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dec,
  input  logic inc,
  output logic has_credit,
  output logic overflow
);

  localparam logic [CREDIT_W-1:0] MAX_V = CREDIT_W'(CREDIT_MAX);

  logic [CREDIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = cnt_q;
    overflow = 1'b0;
    case (credit_op(dec, inc))
      CR_DEC: cnt_d = cnt_q - 1'b1;
      CR_INC: begin
        if (cnt_q == MAX_V) overflow = 1'b1;
        else                cnt_d    = cnt_q + 1'b1;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= MAX_V;
    else        cnt_q <= cnt_d;
  end

  assign has_credit = (cnt_q != '0);

endmodule

// File: rtl/noc_switch_allocator.sv
// Round-robin switch allocator for one VC: wormhole locks, per-output credits,
// zero-cycle grants and registered crossbar selects.
module noc_switch_allocator
  import noc_switch_allocator_pkg::*;
#(
  parameter int PORTS      = PORTS_DEF,
  parameter int LOG_PORTS  = LOG_PORTS_DEF,
  parameter int CREDIT_MAX = CREDIT_MAX_DEF,
  parameter int CREDIT_W   = CREDIT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORTS-1:0]           req_i,
  input  logic [PORTS*LOG_PORTS-1:0] dst_i,
  input  logic [PORTS-1:0]           tail_i,
  input  logic [PORTS-1:0]           credit_in_i,
  output logic [PORTS-1:0]           grant_o,
  output logic [PORTS*LOG_PORTS-1:0] xbar_sel_o,
  output logic [PORTS-1:0]           xbar_vld_o,
  output logic [PORTS-1:0]           lock_o,
  output logic [PORTS*LOG_PORTS-1:0] lock_owner_o,
  output logic                       credit_err_o
);

  typedef struct packed {
    logic                 full;
    logic [LOG_PORTS-1:0] port_no;
  } occupied_t;

  logic [LOG_PORTS-1:0] dst [PORTS];
  occupied_t            occ_q [PORTS];
  occupied_t            occ_d [PORTS];
  logic [LOG_PORTS-1:0] sel_q [PORTS];
  logic [LOG_PORTS-1:0] sel_d [PORTS];
  logic [LOG_PORTS-1:0] out_src [PORTS];
  logic [PORTS-1:0]     vld_q, vld_d;
  logic [PORTS-1:0]     grant, out_gnt, out_tail;
  logic [PORTS-1:0]     has_credit, overflow;
  logic [LOG_PORTS-1:0] rr_ptr_q, rr_ptr_d;
  logic                 credit_err_q, credit_err_d;

  for (genvar g = 0; g < PORTS; g++) begin : g_port
    assign dst[g]                                   = dst_i[g*LOG_PORTS +: LOG_PORTS];
    assign xbar_sel_o[g*LOG_PORTS +: LOG_PORTS]     = sel_q[g];
    assign lock_owner_o[g*LOG_PORTS +: LOG_PORTS]   = occ_q[g].port_no;
    assign lock_o[g]                                = occ_q[g].full;

    noc_credit_counter #(
      .CREDIT_MAX (CREDIT_MAX),
      .CREDIT_W   (CREDIT_W)
    ) u_cc (
      .clk        (clk),
      .rst_n      (rst_n),
      .dec        (out_gnt[g]),
      .inc        (credit_in_i[g]),
      .has_credit (has_credit[g]),
      .overflow   (overflow[g])
    );
  end

  // Scan inputs from rr_ptr; the first eligible requester of each output wins it.
  always_comb begin : alloc
    logic [LOG_PORTS-1:0] p_idx;
    p_idx    = '0;
    grant    = '0;
    out_gnt  = '0;
    out_tail = '0;
    rr_ptr_d = rr_ptr_q;
    for (int d = 0; d < PORTS; d++) out_src[d] = '0;
    for (int k = 0; k < PORTS; k++) begin
      p_idx = LOG_PORTS'((int'(rr_ptr_q) + k) % PORTS);
      for (int d = 0; d < PORTS; d++) begin
        if (req_i[p_idx] && (dst[p_idx] == LOG_PORTS'(d)) && has_credit[d] &&
            !out_gnt[d] && (!occ_q[d].full || (occ_q[d].port_no == p_idx))) begin
          grant[p_idx] = 1'b1;
          out_gnt[d]   = 1'b1;
          out_src[d]   = p_idx;
          out_tail[d]  = tail_i[p_idx];
          rr_ptr_d     = LOG_PORTS'(next_port(int'(p_idx), PORTS));
        end
      end
    end
  end

  always_comb begin
    vld_d        = out_gnt;
    credit_err_d = credit_err_q | (|overflow);
    for (int d = 0; d < PORTS; d++) begin
      occ_d[d] = occ_q[d];
      sel_d[d] = sel_q[d];
      if (out_gnt[d]) begin
        sel_d[d]         = out_src[d];
        occ_d[d].full    = !out_tail[d];
        occ_d[d].port_no = out_tail[d] ? '0 : out_src[d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      rr_ptr_q     <= '0;
      credit_err_q <= 1'b0;
      for (int d = 0; d < PORTS; d++) begin
        occ_q[d] <= '0;
        sel_q[d] <= '0;
      end
    end else begin
      vld_q        <= vld_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_err_q <= credit_err_d;
      for (int d = 0; d < PORTS; d++) begin
        occ_q[d] <= occ_d[d];
        sel_q[d] <= sel_d[d];
      end
    end
  end

  // Grants are suppressed the instant reset asserts, independent of the clock.
  assign grant_o      = rst_n ? grant : '0;
  assign xbar_vld_o   = vld_q;
  assign credit_err_o = credit_err_q;

endmodule
